// File: rtl/xfcp_pkg.sv
// Shared XFCP definitions: arbiter state encodings, byte width and default response timeout.
package xfcp_pkg;

    localparam int XFCP_BYTE_W          = 8;
    localparam int XFCP_TIMEOUT_DEFAULT = 65535;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_GRANT     = 2'd1;
    localparam logic [1:0] ST_WAIT_RESP = 2'd2;

endpackage

// File: rtl/xfcp_rr_select.sv
// Combinational round-robin picker: first requesting port at or after the start pointer.
module xfcp_rr_select
    import xfcp_pkg::*;
#(
    parameter int PORTS     = 2,
    parameter int SEL_WIDTH = $clog2(PORTS)
) (
    input  logic [PORTS-1:0]     req,
    input  logic [SEL_WIDTH-1:0] start,
    output logic [PORTS-1:0]     grant,
    output logic [SEL_WIDTH-1:0] index,
    output logic                 valid
);

    logic [SEL_WIDTH-1:0] cand;

    always_comb begin
        grant = '0;
        index = '0;
        valid = 1'b0;
        cand  = '0;
        for (int i = 0; i < PORTS; i++) begin
            cand = SEL_WIDTH'((int'(start) + i) % PORTS);
            if (!valid && req[cand]) begin
                valid       = 1'b1;
                index       = cand;
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/xfcp_switch_arb_ctrl.sv
// Packet-level arbiter for an XFCP N-to-1 switch: grants one upstream port per
// request/response transaction and steers the response back to it.
module xfcp_switch_arb_ctrl
    import xfcp_pkg::*;
#(
    parameter int PORTS     = 2,
    parameter int TIMEOUT   = XFCP_TIMEOUT_DEFAULT,
    parameter int SEL_WIDTH = $clog2(PORTS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [PORTS-1:0]     up_req_valid,
    input  logic                 down_out_tvalid,
    input  logic                 down_out_tready,
    input  logic                 down_out_tlast,
    input  logic                 down_in_tvalid,
    input  logic                 down_in_tready,
    input  logic                 down_in_tlast,
    output logic [PORTS-1:0]     req_grant,
    output logic [SEL_WIDTH-1:0] req_grant_index,
    output logic [PORTS-1:0]     resp_select,
    output logic                 resp_discard,
    output logic                 busy,
    output logic                 timeout
);

    localparam int                   CNT_W     = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]     CNT_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [SEL_WIDTH-1:0] LAST_PORT = SEL_WIDTH'(PORTS - 1);

    logic [1:0]           state;
    logic [SEL_WIDTH-1:0] owner;
    logic [PORTS-1:0]     owner_oh;
    logic [SEL_WIDTH-1:0] rr_ptr;
    logic                 resp_done;
    logic                 discard_active;
    logic [CNT_W-1:0]     wait_cnt;

    logic [PORTS-1:0]     sel_grant;
    logic [SEL_WIDTH-1:0] sel_index;
    logic                 sel_valid;
    logic [SEL_WIDTH-1:0] ptr_after_owner;

    logic req_tail;
    logic resp_beat;
    logic resp_tail;
    logic resp_owned_tail;

    xfcp_rr_select #(
        .PORTS     (PORTS),
        .SEL_WIDTH (SEL_WIDTH)
    ) u_rr_select (
        .req   (up_req_valid),
        .start (rr_ptr),
        .grant (sel_grant),
        .index (sel_index),
        .valid (sel_valid)
    );

    assign req_tail        = down_out_tvalid && down_out_tready && down_out_tlast;
    assign resp_beat       = down_in_tvalid && down_in_tready;
    assign resp_tail       = resp_beat && down_in_tlast;
    // Beats belonging to a stray packet being drained never complete our transaction.
    assign resp_owned_tail = resp_tail && !discard_active;
    assign ptr_after_owner = (owner == LAST_PORT) ? '0 : owner + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= ST_IDLE;
            owner          <= '0;
            owner_oh       <= '0;
            rr_ptr         <= '0;
            resp_done      <= 1'b0;
            discard_active <= 1'b0;
            wait_cnt       <= '0;
            timeout        <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                ST_IDLE: begin
                    resp_done <= 1'b0;
                    if (sel_valid) begin
                        owner    <= sel_index;
                        owner_oh <= sel_grant;
                        state    <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (req_tail) begin
                        // Response may have completed before the request tail drained.
                        if (resp_done || resp_owned_tail) begin
                            state     <= ST_IDLE;
                            resp_done <= 1'b0;
                            rr_ptr    <= ptr_after_owner;
                        end else begin
                            state    <= ST_WAIT_RESP;
                            wait_cnt <= '0;
                        end
                    end else if (resp_owned_tail) begin
                        resp_done <= 1'b1;
                    end
                end
                ST_WAIT_RESP: begin
                    if (resp_owned_tail) begin
                        state  <= ST_IDLE;
                        rr_ptr <= ptr_after_owner;
                    end else if (resp_beat) begin
                        wait_cnt <= '0;
                    end else if (wait_cnt == CNT_LAST) begin
                        timeout <= 1'b1;
                        state   <= ST_IDLE;
                        rr_ptr  <= ptr_after_owner;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase

            // A packet that starts draining in IDLE keeps draining until its tail.
            if (discard_active) begin
                if (resp_tail) begin
                    discard_active <= 1'b0;
                end
            end else if (state == ST_IDLE && resp_beat && !down_in_tlast) begin
                discard_active <= 1'b1;
            end
        end
    end

    assign busy            = (state != ST_IDLE);
    assign req_grant_index = owner;
    assign req_grant       = (state == ST_GRANT) ? owner_oh : '0;
    assign resp_select     = ((state == ST_GRANT || state == ST_WAIT_RESP) && !discard_active)
                             ? owner_oh : '0;
    assign resp_discard    = (state == ST_IDLE) || discard_active;

endmodule

// File: tb/tb_xfcp_switch_arb_ctrl.sv
// Directed and randomized transaction-level checks of the XFCP switch arbiter.
module tb_xfcp_switch_arb_ctrl;

    localparam int PORTS = 2;
    localparam int TO    = 8;

    logic             clk;
    logic             rst;
    logic [PORTS-1:0] up_req_valid;
    logic             down_out_tvalid, down_out_tready, down_out_tlast;
    logic             down_in_tvalid, down_in_tready, down_in_tlast;
    logic [PORTS-1:0] req_grant;
    logic             req_grant_index;
    logic [PORTS-1:0] resp_select;
    logic             resp_discard;
    logic             busy;
    logic             timeout;

    int n_checks = 0;
    int n_errors = 0;
    int ptr      = 0;

    xfcp_switch_arb_ctrl #(
        .PORTS   (PORTS),
        .TIMEOUT (TO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .up_req_valid    (up_req_valid),
        .down_out_tvalid (down_out_tvalid),
        .down_out_tready (down_out_tready),
        .down_out_tlast  (down_out_tlast),
        .down_in_tvalid  (down_in_tvalid),
        .down_in_tready  (down_in_tready),
        .down_in_tlast   (down_in_tlast),
        .req_grant       (req_grant),
        .req_grant_index (req_grant_index),
        .resp_select     (resp_select),
        .resp_discard    (resp_discard),
        .busy            (busy),
        .timeout         (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no end, expected summary");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "/busy"}, 32'(busy), 0);
        chk({tag, "/grant"}, 32'(req_grant), 0);
        chk({tag, "/sel"}, 32'(resp_select), 0);
        chk({tag, "/discard"}, 32'(resp_discard), 1);
    endtask

    task automatic chk_grant(input string tag, input int p);
        chk({tag, "/grant"}, 32'(req_grant), 32'(1 << p));
        chk({tag, "/index"}, 32'(req_grant_index), 32'(p));
        chk({tag, "/sel"}, 32'(resp_select), 32'(1 << p));
        chk({tag, "/discard"}, 32'(resp_discard), 0);
        chk({tag, "/busy"}, 32'(busy), 1);
        chk({tag, "/timeout"}, 32'(timeout), 0);
    endtask

    task automatic chk_wait(input string tag, input int p);
        chk({tag, "/grant"}, 32'(req_grant), 0);
        chk({tag, "/sel"}, 32'(resp_select), 32'(1 << p));
        chk({tag, "/busy"}, 32'(busy), 1);
        chk({tag, "/timeout"}, 32'(timeout), 0);
    endtask

    task automatic req_beat(input logic last);
        down_out_tvalid = 1'b1;
        down_out_tready = 1'b1;
        down_out_tlast  = last;
        tick();
        down_out_tvalid = 1'b0;
        down_out_tready = 1'b0;
        down_out_tlast  = 1'b0;
    endtask

    task automatic resp_beat(input logic last);
        down_in_tvalid = 1'b1;
        down_in_tready = 1'b1;
        down_in_tlast  = last;
        tick();
        down_in_tvalid = 1'b0;
        down_in_tready = 1'b0;
        down_in_tlast  = 1'b0;
    endtask

    // Request beat preceded by up to two non-accepting cycles; grant must hold throughout.
    task automatic req_beat_stalled(input logic last, input int p);
        int n;
        n = $urandom_range(0, 2);
        for (int s = 0; s < n; s++) begin
            down_out_tvalid = 1'($urandom_range(0, 1));
            down_out_tready = ~down_out_tvalid;
            down_out_tlast  = last;
            tick();
            chk_grant("rnd_req_stall", p);
        end
        req_beat(last);
    endtask

    initial begin
        logic [1:0]  mask;
        int unsigned mv;
        int          win;
        int          mode;
        int          len;
        int          m;
        int          gap;

        rst             = 1'b0;
        up_req_valid    = '0;
        down_out_tvalid = 1'b0;
        down_out_tready = 1'b0;
        down_out_tlast  = 1'b0;
        down_in_tvalid  = 1'b0;
        down_in_tready  = 1'b0;
        down_in_tlast   = 1'b0;
        tick();
        tick();
        chk_idle("reset");
        chk("reset/index", 32'(req_grant_index), 0);
        chk("reset/timeout", 32'(timeout), 0);
        rst = 1'b1;

        // Port 1 alone: 4-beat request, 3-beat response
        up_req_valid = 2'b10;
        tick();
        chk_grant("t1_grant", 1);
        req_beat(1'b0);
        up_req_valid = 2'b00;
        chk_grant("t1_drop_valid", 1);
        req_beat(1'b0);
        req_beat(1'b0);
        chk_grant("t1_beat3", 1);
        req_beat(1'b1);
        chk_wait("t1_wait", 1);
        resp_beat(1'b0);
        resp_beat(1'b0);
        chk_wait("t1_resp2", 1);
        resp_beat(1'b1);
        chk_idle("t1_done");

        // Both ports continuously: 0,1,0,1 with a single IDLE cycle between
        up_req_valid = 2'b11;
        tick();
        for (int k = 0; k < 4; k++) begin
            chk_grant("t2_grant", k % 2);
            req_beat(1'b1);
            chk_wait("t2_wait", k % 2);
            resp_beat(1'b1);
            chk_idle("t2_idle");
            if (k < 3) tick();
        end
        up_req_valid = 2'b00;

        // Timeout after TO silent cycles in WAIT_RESP, then the other port wins
        up_req_valid = 2'b01;
        tick();
        chk_grant("t3_grant", 0);
        req_beat(1'b1);
        up_req_valid = 2'b11;
        chk_wait("t3_wait", 0);
        for (int i = 1; i <= TO; i++) begin
            tick();
            if (i < TO) begin
                chk("t3_pending/busy", 32'(busy), 1);
                chk("t3_pending/timeout", 32'(timeout), 0);
            end else begin
                chk("t3_expire/timeout", 32'(timeout), 1);
                chk("t3_expire/busy", 32'(busy), 0);
                chk("t3_expire/discard", 32'(resp_discard), 1);
            end
        end
        tick();
        chk_grant("t3_next", 1);
        up_req_valid = 2'b00;
        req_beat(1'b1);
        resp_beat(1'b1);
        chk_idle("t3_done");

        // Response completes while request tail is stalled
        up_req_valid = 2'b01;
        tick();
        chk_grant("t4_grant", 0);
        up_req_valid = 2'b00;
        req_beat(1'b0);
        down_out_tvalid = 1'b1;
        down_out_tlast  = 1'b1;
        down_out_tready = 1'b0;
        resp_beat(1'b1);
        chk_grant("t4_early_resp", 0);
        tick();
        chk_grant("t4_stalled", 0);
        down_out_tready = 1'b1;
        tick();
        down_out_tvalid = 1'b0;
        down_out_tready = 1'b0;
        down_out_tlast  = 1'b0;
        chk_idle("t4_direct_idle");

        // Stray 5-beat response drained across a new grant
        resp_beat(1'b0);
        chk_idle("t5_stray1");
        up_req_valid = 2'b01;
        for (int b = 2; b <= 4; b++) begin
            resp_beat(1'b0);
            chk("t5_drain/grant", 32'(req_grant), 1);
            chk("t5_drain/sel", 32'(resp_select), 0);
            chk("t5_drain/discard", 32'(resp_discard), 1);
        end
        resp_beat(1'b1);
        up_req_valid = 2'b00;
        chk_grant("t5_after_stray", 0);
        req_beat(1'b1);
        chk_wait("t5_wait", 0);
        resp_beat(1'b1);
        chk_idle("t5_done");

        // Asynchronous reset mid-request restarts arbitration from port 0
        up_req_valid = 2'b11;
        tick();
        chk_grant("t6_grant", 1);
        req_beat(1'b0);
        #2;
        rst = 1'b0;
        #1;
        chk_idle("t6_async_reset");
        chk("t6_async_reset/index", 32'(req_grant_index), 0);
        chk("t6_async_reset/timeout", 32'(timeout), 0);
        tick();
        chk_idle("t6_held_reset");
        rst = 1'b1;
        tick();
        chk_grant("t6_restart", 0);
        up_req_valid = 2'b00;
        req_beat(1'b1);
        resp_beat(1'b1);
        chk_idle("t6_done");
        ptr = 1;

        // Randomized transactions against a round-robin transaction model
        for (int t = 0; t < 40; t++) begin
            mask = 2'($urandom_range(1, 3));
            mv   = 32'(mask);
            win  = -1;
            for (int k = 0; k < PORTS; k++) begin
                int p;
                p = (ptr + k) % PORTS;
                if (win < 0 && ((mv >> p) & 1) != 0) win = p;
            end
            up_req_valid = mask;
            tick();
            chk_grant("rnd_grant", win);
            up_req_valid = 2'($urandom_range(0, 3));
            mode = $urandom_range(0, 2);
            len  = $urandom_range(1, 4);
            for (int b = 0; b < len - 1; b++) begin
                req_beat_stalled(1'b0, win);
                chk_grant("rnd_req_body", win);
            end
            if (mode == 1) begin
                down_out_tvalid = 1'b1;
                down_out_tlast  = 1'b1;
                down_out_tready = 1'b0;
                m = $urandom_range(1, 3);
                for (int b = 0; b < m; b++) begin
                    resp_beat(b == m - 1);
                    chk_grant("rnd_early_resp", win);
                end
                tick();
                chk_grant("rnd_early_hold", win);
                down_out_tready = 1'b1;
                tick();
                down_out_tvalid = 1'b0;
                down_out_tready = 1'b0;
                down_out_tlast  = 1'b0;
                chk_idle("rnd_early_end");
                chk("rnd_early_end/timeout", 32'(timeout), 0);
            end else begin
                req_beat_stalled(1'b1, win);
                chk_wait("rnd_req_tail", win);
                if (mode == 0) begin
                    m = $urandom_range(1, 3);
                    for (int b = 0; b < m; b++) begin
                        gap = $urandom_range(0, 3);
                        for (int g = 0; g < gap; g++) begin
                            down_in_tvalid = 1'($urandom_range(0, 1));
                            down_in_tready = ~down_in_tvalid;
                            tick();
                            chk_wait("rnd_resp_gap", win);
                        end
                        resp_beat(b == m - 1);
                        if (b < m - 1) chk_wait("rnd_resp_body", win);
                    end
                    chk_idle("rnd_resp_end");
                    chk("rnd_resp_end/timeout", 32'(timeout), 0);
                end else begin
                    m = $urandom_range(0, 2);
                    for (int b = 0; b < m; b++) begin
                        resp_beat(1'b0);
                        chk_wait("rnd_to_partial", win);
                    end
                    for (int i = 1; i <= TO; i++) begin
                        tick();
                        if (i < TO) begin
                            chk("rnd_to_pending/busy", 32'(busy), 1);
                            chk("rnd_to_pending/timeout", 32'(timeout), 0);
                        end else begin
                            chk("rnd_to_expire/timeout", 32'(timeout), 1);
                            chk("rnd_to_expire/busy", 32'(busy), 0);
                        end
                    end
                end
            end
            ptr = (win + 1) % PORTS;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
